// File: rtl/pick_sum_referee_if.sv
// Player-facing bundle of the pick-to-sum referee: front-end controls in,
// board/status display signals out, plus an FSM state view for checkers.
interface pick_sum_referee_if #(
    parameter int PICKS = 5,
    parameter int NW    = 4
);
    // Handshake: enter_L is an active-low level from a synchronised button.
    // A low level seen in a TURN state is one press; move is sampled only on
    // that edge. The press completes when enter_L returns high (HOLD state).
    // newGame_L low at any edge clears the game and outranks enter_L.
    logic [NW-1:0]       move;
    logic                enter_L;
    logic                newGame_L;
    logic                turn;
    logic [PICKS*NW-1:0] p1_hist;
    logic [PICKS*NW-1:0] p2_hist;
    logic                invalid;
    logic                win_p1;
    logic                win_p2;
    logic                draw;
    logic [2:0]          state_dbg;

    modport master (
        output move, enter_L, newGame_L,
        input  turn, p1_hist, p2_hist, invalid, win_p1, win_p2, draw, state_dbg
    );

    modport slave (
        input  move, enter_L, newGame_L,
        output turn, p1_hist, p2_hist, invalid, win_p1, win_p2, draw, state_dbg
    );
endinterface

// File: rtl/pick_sum_referee.sv
// Two-player pick-to-sum referee: arbitrates turns, rejects illegal picks,
// keeps each player's picks sorted and flags a TARGET triple or a draw.
module pick_sum_referee #(
    parameter int MAX_NUM = 9,
    parameter int TARGET  = 15,
    parameter int PICKS   = 5,
    parameter int NW      = 4
) (
    input  logic               clock,
    input  logic               reset_L,
    pick_sum_referee_if.slave  bus
);
    localparam int CW = $clog2(PICKS + 1);
    localparam int SW = NW + 2;
    localparam int TW = 1 << NW;

    typedef enum logic [2:0] {
        P1_TURN = 3'd0,
        P1_HOLD = 3'd1,
        P2_TURN = 3'd2,
        P2_HOLD = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] taken_q, taken_d;
    logic [NW-1:0] h1_q [PICKS];
    logic [NW-1:0] h1_d [PICKS];
    logic [NW-1:0] h2_q [PICKS];
    logic [NW-1:0] h2_d [PICKS];
    logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic          turn_q, turn_d;
    logic          invalid_q, invalid_d;
    logic          win1_q, win1_d, win2_q, win2_d;
    logic          draw_q, draw_d;

    // Press evaluation signals
    logic          press, mover, legal, win_new, draw_new, all_taken;
    logic [CW-1:0] cnt_m, cnt_o, pos;
    logic [NW-1:0] hist_m [PICKS];
    logic [NW-1:0] ins    [PICKS];
    logic [TW-1:0] taken_new;
    logic [SW-1:0] s;

    // FSM state register
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state_q <= P1_TURN;
        else          state_q <= state_d;
    end

    // FSM next-state: one press per low level, release hands over the turn
    always_comb begin
        state_d = state_q;
        if (!bus.newGame_L) begin
            state_d = P1_TURN;
        end else begin
            case (state_q)
                P1_TURN: if (!bus.enter_L) state_d = P1_HOLD;
                P2_TURN: if (!bus.enter_L) state_d = P2_HOLD;
                P1_HOLD, P2_HOLD: begin
                    if (bus.enter_L) begin
                        if (win1_q || win2_q || draw_q) state_d = DONE;
                        else if (turn_d)                state_d = P2_TURN;
                        else                            state_d = P1_TURN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Move validation, sorted insertion and win/draw evaluation for a press
    always_comb begin
        press  = bus.newGame_L && !bus.enter_L &&
                 (state_q == P1_TURN || state_q == P2_TURN);
        mover  = (state_q == P2_TURN);
        cnt_m  = mover ? cnt2_q : cnt1_q;
        cnt_o  = mover ? cnt1_q : cnt2_q;
        hist_m = mover ? h2_q : h1_q;
        legal  = (bus.move >= NW'(1)) && (bus.move <= NW'(MAX_NUM)) &&
                 !taken_q[bus.move] && (cnt_m < CW'(PICKS));

        // Insert position = held (non-zero) entries smaller than the move
        pos = '0;
        for (int k = 0; k < PICKS; k++) begin
            if (hist_m[k] != '0 && hist_m[k] < bus.move) pos = pos + 1'b1;
        end
        ins[0] = (pos == '0) ? bus.move : hist_m[0];
        for (int k = 1; k < PICKS; k++) begin
            if (CW'(k) < pos)       ins[k] = hist_m[k];
            else if (CW'(k) == pos) ins[k] = bus.move;
            else                    ins[k] = hist_m[k-1];
        end

        // Any three distinct non-zero slots at full width, no wrap
        win_new = 1'b0;
        s       = '0;
        for (int i = 0; i < PICKS; i++) begin
            for (int j = i + 1; j < PICKS; j++) begin
                for (int k = j + 1; k < PICKS; k++) begin
                    s = SW'(ins[i]) + SW'(ins[j]) + SW'(ins[k]);
                    if (ins[i] != '0 && ins[j] != '0 && ins[k] != '0 &&
                        s == SW'(TARGET))
                        win_new = 1'b1;
                end
            end
        end

        taken_new           = taken_q;
        taken_new[bus.move] = 1'b1;
        all_taken           = &taken_new[MAX_NUM:1];
        draw_new            = !win_new && (all_taken || cnt_o == CW'(PICKS));
    end

    // Datapath next values: clear, accept/reject a press, flip turn on release
    always_comb begin
        taken_d   = taken_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        turn_d    = turn_q;
        invalid_d = invalid_q;
        win1_d    = win1_q;
        win2_d    = win2_q;
        draw_d    = draw_q;
        if (!bus.newGame_L) begin
            taken_d   = '0;
            for (int k = 0; k < PICKS; k++) begin
                h1_d[k] = '0;
                h2_d[k] = '0;
            end
            cnt1_d    = '0;
            cnt2_d    = '0;
            turn_d    = 1'b0;
            invalid_d = 1'b0;
            win1_d    = 1'b0;
            win2_d    = 1'b0;
            draw_d    = 1'b0;
        end else if (press) begin
            if (legal) begin
                taken_d   = taken_new;
                invalid_d = 1'b0;
                draw_d    = draw_new;
                if (mover) begin
                    h2_d   = ins;
                    cnt2_d = cnt2_q + 1'b1;
                    win2_d = win_new;
                end else begin
                    h1_d   = ins;
                    cnt1_d = cnt1_q + 1'b1;
                    win1_d = win_new;
                end
            end else begin
                invalid_d = 1'b1;
            end
        end else if ((state_q == P1_HOLD || state_q == P2_HOLD) && bus.enter_L) begin
            // A rejected press leaves the same player to move again
            turn_d = invalid_q ? turn_q : ~turn_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            taken_q   <= '0;
            for (int k = 0; k < PICKS; k++) begin
                h1_q[k] <= '0;
                h2_q[k] <= '0;
            end
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            turn_q    <= 1'b0;
            invalid_q <= 1'b0;
            win1_q    <= 1'b0;
            win2_q    <= 1'b0;
            draw_q    <= 1'b0;
        end else begin
            taken_q   <= taken_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            turn_q    <= turn_d;
            invalid_q <= invalid_d;
            win1_q    <= win1_d;
            win2_q    <= win2_d;
            draw_q    <= draw_d;
        end
    end

    // Outputs: straight from registers, histories packed slot k at [k*NW +: NW]
    always_comb begin
        bus.turn      = turn_q;
        bus.invalid   = invalid_q;
        bus.win_p1    = win1_q;
        bus.win_p2    = win2_q;
        bus.draw      = draw_q;
        bus.state_dbg = state_q;
        bus.p1_hist   = '0;
        bus.p2_hist   = '0;
        for (int k = 0; k < PICKS; k++) begin
            bus.p1_hist[k*NW +: NW] = h1_q[k];
            bus.p2_hist[k*NW +: NW] = h2_q[k];
        end
    end
endmodule

// File: tb/tb_pick_sum_referee.sv
// Bench for pick_sum_referee: a game model predicts the board after each
// press; predictions are queued at the press and compared after it lands.
module tb_pick_sum_referee;
    localparam int NW    = 4;
    localparam int PICKS = 5;
    localparam int W     = 45;

    logic clock   = 1'b0;
    logic reset_L = 1'b0;

    always #5 clock = ~clock;

    pick_sum_referee_if #(.PICKS(PICKS), .NW(NW)) bus ();

    pick_sum_referee #(.MAX_NUM(9), .TARGET(15), .PICKS(PICKS), .NW(NW)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Game model
    logic [15:0] m_taken;
    int          m_l1[$];
    int          m_l2[$];
    logic        m_turn, m_inv, m_w1, m_w2, m_draw;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack_hist(input int l[$]);
        int s[$];
        logic [19:0] r;
        s = l;
        s.sort();
        r = '0;
        foreach (s[k]) r[k*4 +: 4] = s[k][3:0];
        return r;
    endfunction

    function automatic bit has_win(input int l[$]);
        bit w = 0;
        for (int a = 0; a < l.size(); a++)
            for (int b = a + 1; b < l.size(); b++)
                for (int c = b + 1; c < l.size(); c++)
                    if (l[a] + l[b] + l[c] == 15) w = 1;
        return w;
    endfunction

    task automatic m_reset();
        m_taken = '0;
        m_l1.delete();
        m_l2.delete();
        m_turn = 0; m_inv = 0; m_w1 = 0; m_w2 = 0; m_draw = 0;
    endtask

    task automatic m_apply(input int mv);
        int cnt, other;
        if (m_w1 || m_w2 || m_draw) return;
        cnt   = m_turn ? m_l2.size() : m_l1.size();
        other = m_turn ? m_l1.size() : m_l2.size();
        if (mv < 1 || mv > 9 || m_taken[mv] || cnt >= PICKS) begin
            m_inv = 1;
            return;
        end
        m_inv = 0;
        m_taken[mv] = 1'b1;
        if (m_turn) begin
            m_l2.push_back(mv);
            m_w2 = has_win(m_l2);
        end else begin
            m_l1.push_back(mv);
            m_w1 = has_win(m_l1);
        end
        m_draw = !(m_w1 || m_w2) && ((&m_taken[9:1]) || other == PICKS);
        m_turn = ~m_turn;
    endtask

    function automatic logic [W-1:0] m_pack();
        return {m_turn, m_inv, m_w1, m_w2, m_draw, pack_hist(m_l1), pack_hist(m_l2)};
    endfunction

    // Compare the present outputs against the model with no press pending
    task automatic compare_now(input string tag);
        logic [W-1:0] e;
        e = m_pack();
        chk({tag, "_p1"},    bus.p1_hist, e[39:20]);
        chk({tag, "_p2"},    bus.p2_hist, e[19:0]);
        chk({tag, "_flags"}, {bus.invalid, bus.win_p1, bus.win_p2, bus.draw}, e[43:40]);
        chk({tag, "_turn"},  bus.turn, e[44]);
    endtask

    // Called at the negedge before the press edge, enter_L already low
    task automatic finish_press(input string tag, input int hold_cycles);
        logic [W-1:0] e;
        @(negedge clock);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
            e = m_pack();
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_p1"},    bus.p1_hist, e[39:20]);
        chk({tag, "_p2"},    bus.p2_hist, e[19:0]);
        chk({tag, "_flags"}, {bus.invalid, bus.win_p1, bus.win_p2, bus.draw}, e[43:40]);
        repeat (hold_cycles) @(negedge clock);
        bus.enter_L = 1'b1;
        @(negedge clock);
        chk({tag, "_turn"}, bus.turn, e[44]);
    endtask

    task automatic do_press(input string tag, input int mv);
        @(negedge clock);
        bus.move    = mv[NW-1:0];
        bus.enter_L = 1'b0;
        m_apply(mv);
        exp_q.push_back(m_pack());
        finish_press(tag, 0);
    endtask

    task automatic new_game();
        @(negedge clock);
        bus.newGame_L = 1'b0;
        @(negedge clock);
        bus.newGame_L = 1'b1;
        m_reset();
    endtask

    initial begin
        int seq_win[7];
        int seq_draw[9];
        seq_win  = '{5, 6, 1, 9, 3, 2, 7};
        seq_draw = '{2, 7, 6, 5, 9, 1, 3, 4, 8};
        bus.move      = '0;
        bus.enter_L   = 1'b1;
        bus.newGame_L = 1'b1;
        m_reset();

        // Reset and idle inputs
        repeat (3) @(negedge clock);
        reset_L = 1'b1;
        compare_now("reset");
        chk("reset_state", bus.state_dbg, 3'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.move = NW'($urandom_range(0, 15));
        end
        @(negedge clock);
        compare_now("idle");

        // P1 wins with 5,1,3,7
        foreach (seq_win[i]) do_press("win", seq_win[i]);
        chk("win_hist", bus.p1_hist, 20'h07531);
        chk("win_state", bus.state_dbg, 3'd4);
        do_press("done_ignore", 4);
        chk("done_state", bus.state_dbg, 3'd4);
        new_game();
        compare_now("newgame");

        // Invalid moves: repeat, zero, out of range, then good
        do_press("inv_p1", 5);
        do_press("inv_dup", 5);
        do_press("inv_zero", 0);
        do_press("inv_big", 10);
        do_press("inv_ok", 6);
        chk("inv_turn", bus.turn, 1'b0);
        new_game();

        // Held button: move changes mid-hold, only one press recorded
        @(negedge clock);
        bus.move    = 4'd4;
        bus.enter_L = 1'b0;
        m_apply(4);
        exp_q.push_back(m_pack());
        @(negedge clock);
        bus.move = 4'd8;
        finish_press("hold", 4);
        chk("hold_slot", bus.p1_hist, 20'h00004);
        new_game();

        // Draw
        foreach (seq_draw[i]) do_press("draw", seq_draw[i]);
        chk("draw_p1", bus.p1_hist, 20'h98632);
        chk("draw_p2", bus.p2_hist, 20'h07541);
        chk("draw_state", bus.state_dbg, 3'd4);
        new_game();

        // newGame_L coincident with a press mid-game
        do_press("pre_clr", 3);
        do_press("pre_clr", 8);
        @(negedge clock);
        bus.move      = 4'd7;
        bus.enter_L   = 1'b0;
        bus.newGame_L = 1'b0;
        @(negedge clock);
        bus.enter_L   = 1'b1;
        bus.newGame_L = 1'b1;
        m_reset();
        compare_now("clr_press");
        chk("clr_state", bus.state_dbg, 3'd0);

        // Async reset between edges, enter_L still low at release
        do_press("pre_rst", 2);
        @(posedge clock);
        #2;
        reset_L     = 1'b0;
        bus.enter_L = 1'b0;
        bus.move    = 4'd3;
        #1;
        m_reset();
        compare_now("async_rst");
        @(negedge clock);
        reset_L = 1'b1;
        m_apply(3);
        exp_q.push_back(m_pack());
        finish_press("rst_press", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
